// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the boot loader
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing little-endian words into instruction memory
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_t      state, state_next;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] n_rx;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [7:0]  xor_acc;
  logic        rx_fire;
  logic        start_load;
  logic        last_byte;

  assign rx_fire    = bus.rx_valid && bus.rx_ready;
  assign n_rx       = {bus.rx_data, len_lo};
  assign last_byte  = (lane == 2'd3) && (word_count + 16'd1 == n_words);
  assign start_load = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    bus.rx_ready = 1'b0;
    busy         = 1'b0;
    core_hold    = 1'b1;
    done         = 1'b0;
    error        = 1'b0;
    case (state)
      S_IDLE: if (start) state_next = S_LEN_LO;
      S_LEN_LO: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (bus.rx_valid) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (bus.rx_valid) begin
          if ({1'b0, n_rx} > MAX_WORDS) state_next = S_ERROR;
          else if (n_rx == 16'd0)       state_next = S_CHECK;
          else                          state_next = S_DATA;
        end
      end
      S_DATA: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (bus.rx_valid && last_byte) state_next = S_CHECK;
      end
      S_CHECK: begin
        bus.rx_ready = 1'b1;
        busy         = 1'b1;
        if (bus.rx_valid) state_next = (bus.rx_data == xor_acc) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        core_hold = 1'b0;
        done      = 1'b1;
        if (start) state_next = S_LEN_LO;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN_LO;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Bytes shift in from the top so byte 0 lands in bits 7:0 once the 4th byte arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo         <= 8'd0;
      n_words        <= 16'd0;
      lane           <= 2'd0;
      word_buf       <= 24'd0;
      xor_acc        <= 8'd0;
      word_count     <= 16'd0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= 32'd0;
    end else begin
      bus.imem_we <= 1'b0;
      if (start_load) begin
        lane       <= 2'd0;
        xor_acc    <= 8'd0;
        word_count <= 16'd0;
      end else if (rx_fire) begin
        case (state)
          S_LEN_LO: len_lo  <= bus.rx_data;
          S_LEN_HI: n_words <= n_rx;
          S_DATA: begin
            xor_acc <= xor_acc ^ bus.rx_data;
            lane    <= lane + 2'd1;
            if (lane == 2'd3) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {bus.rx_data, word_buf};
              bus.imem_addr  <= word_count[ADDR_W-1:0];
              word_count     <= word_count + 16'd1;
            end else begin
              word_buf <= {bus.rx_data, word_buf[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        core_hold, busy, done, error;
  logic [15:0] word_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [ADDR_W+31:0] exp_q [$];

  logic [7:0]  img [0:11] = '{8'h93, 8'h00, 8'hA0, 8'h00,
                               8'h13, 8'h01, 8'h50, 8'h00,
                               8'hB3, 8'h81, 8'h20, 8'h00};
  logic [31:0] words [0:2] = '{32'h00A00093, 32'h00500113, 32'h002081B3};

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus.slave),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe cycle must match the next expected write.
  always @(negedge clk) begin
    if (!rst && bus.imem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h", bus.imem_addr, bus.imem_wdata);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.imem_addr), 32'(e[ADDR_W+31:32]));
        check("write_data", bus.imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    last_acc     = cyc;
    bus.rx_valid = 1'b0;
  endtask

  task automatic begin_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_writes();
    for (int i = 0; i < 3; i++) exp_q.push_back({ADDR_W'(i), words[i]});
  endtask

  task automatic send_frame(input bit throttle, input logic [7:0] csum);
    send_byte(8'h03);
    if (throttle) begin @(posedge clk); #1; end
    send_byte(8'h00);
    for (int i = 0; i < 12; i++) begin
      if (throttle) begin @(posedge clk); #1; end
      send_byte(img[i]);
    end
    if (throttle) begin @(posedge clk); #1; end
    send_byte(csum);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_core_hold"}, 32'(core_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic d, input logic e, input logic [15:0] wc);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_core_hold"}, 32'(core_hold), 32'(!d));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'(wc));
  endtask

  initial begin
    int first_acc;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #1 rst = 1'b1;
    #2 check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Good 3-word load
    begin_load();
    check("start_busy", 32'(busy), 32'd1);
    check("start_rx_ready", 32'(bus.rx_ready), 32'd1);
    push_writes();
    send_frame(1'b0, 8'h63);
    check_result("good", 1'b1, 1'b0, 16'd3);

    // Bad checksum
    begin_load();
    check("restart_clears_done", 32'(done), 32'd0);
    push_writes();
    send_frame(1'b0, 8'h00);
    check_result("badsum", 1'b0, 1'b1, 16'd3);

    // Empty image
    begin_load();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check_result("empty", 1'b1, 1'b0, 16'd0);

    // Oversize image: N = 1025
    begin_load();
    send_byte(8'h01);
    send_byte(8'h04);
    check("oversize_error", 32'(error), 32'd1);
    check("oversize_rx_ready", 32'(bus.rx_ready), 32'd0);
    bus.rx_data  = 8'h55;
    bus.rx_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("oversize_no_accept", 32'(bus.rx_ready), 32'd0);
    end
    bus.rx_valid = 1'b0;
    check_result("oversize", 1'b0, 1'b1, 16'd0);

    // Throttled stream
    begin_load();
    push_writes();
    send_frame(1'b1, 8'h63);
    check_result("throttled", 1'b1, 1'b0, 16'd3);

    // Full-rate: 15 bytes on 15 consecutive edges
    begin_load();
    push_writes();
    send_byte(8'h03);
    first_acc = last_acc;
    send_byte(8'h00);
    for (int i = 0; i < 12; i++) send_byte(img[i]);
    send_byte(8'h63);
    check("fullrate_span", 32'(last_acc - first_acc), 32'd14);
    check_result("fullrate", 1'b1, 1'b0, 16'd3);

    // Reset after 5 data bytes
    begin_load();
    exp_q.push_back({ADDR_W'(0), words[0]});
    send_byte(8'h03);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(img[i]);
    #2 rst = 1'b1;
    #1 check_reset_vals("midreset");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    begin_load();
    push_writes();
    send_frame(1'b0, 8'h63);
    check_result("after_reset", 1'b1, 1'b0, 16'd3);

    // Start while busy is ignored
    begin_load();
    push_writes();
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(img[0]);
    send_byte(img[1]);
    begin_load();
    check("start_busy_ignored", 32'(busy), 32'd1);
    for (int i = 2; i < 12; i++) send_byte(img[i]);
    send_byte(8'h63);
    check_result("busy_start", 1'b1, 1'b0, 16'd3);

    repeat (3) @(posedge clk);
    #1 check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded");
    $fatal(1, "timeout");
  end
endmodule
